parallax_vga_timing: RTL and testbench
======================================

PARALLAX_VGA_TIMING -- requirements
Module: parallax_vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 24, H_SYNC 64, H_BACK 104: horizontal blanking segments, in that order after active.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FRONT 9, V_SYNC 3, V_BACK 28: lines per vertical segment, same order.
REQ-004 SHALL have parameters HSYNC_POL 0, VSYNC_POL 0: asserted sync level (0 = active-low).
REQ-005 SHALL have parameters RGB_W 3 (colour width) and PIPE 2 (external pixel-source latency in pixel ticks, >=1).
REQ-006 SHALL have port clk, input, 1: single clock.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port pix_en, input, 1: pixel tick enable.
REQ-009 SHALL have port rgb_in, input, RGB_W: colour from the pixel source for the x,y issued PIPE ticks earlier.
REQ-010 SHALL have ports x and y, output, 10 each: current horizontal and vertical counter values.
REQ-011 SHALL have ports active, line_start, frame_start, output, 1 each: decode of the current counters.
REQ-012 SHALL have port frame_cnt, output, 8: completed-frame count.
REQ-013 SHALL have ports hsync, vsync (output, 1) and rgb (output, RGB_W): delayed, aligned video outputs.

Function
REQ-014 SHALL run h counter 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (832 by default); it advances only on clocks with pix_en=1.
REQ-015 SHALL wrap h from H_TOTAL-1 to 0 and, on the same tick, advance v; v wraps V_TOTAL-1 to 0 (V_TOTAL 520 by default).
REQ-016 SHALL increment frame_cnt (mod 256) on the tick where v and h both wrap.
REQ-017 SHALL drive active=1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-018 SHALL drive line_start=1 iff h=0, and frame_start=1 iff h=0 and v=0.
REQ-019 SHALL define raw hsync asserted for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC, and raw vsync asserted for V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC.
REQ-020 SHALL apply HSYNC_POL/VSYNC_POL to the asserted level; the deasserted level is the inverse.
REQ-021 SHALL delay raw hsync, raw vsync and active through a PIPE-stage shift register advancing only on pix_en ticks.
REQ-022 SHALL register rgb = rgb_in when the delayed active is 1, else 0, on pix_en ticks, in the same stage as hsync/vsync.
REQ-023 SHALL hold counters, pipeline and all outputs unchanged on clocks with pix_en=0.
REQ-024 SHALL never emit non-zero rgb while delayed hsync or vsync is asserted.

Reset
REQ-025 SHALL on reset low asynchronously clear h, v and frame_cnt to 0 and the pipeline to inactive.
REQ-026 SHALL hold during reset: hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, rgb = 0, x = y = 0.
REQ-027 SHALL restart at h=v=0 with frame_start=1 on the first clock after reset release; reset mid-frame SHALL abandon the frame without a partial sync pulse.

Structure
REQ-028 SHALL place the default timing constants (640/24/64/104, 480/9/3/28) and the derived H_TOTAL/V_TOTAL function in a shared package vga_timing_pkg.
REQ-029 SHALL implement the delay line as a sub-module vga_delay_line (parameters WIDTH, DEPTH, with an enable input).
REQ-030 SHALL elaborate-time-check that each timing parameter is >=1 and PIPE >=1.

Verification
REQ-031 SHALL cover: defaults, pix_en=1 -> hsync low exactly 64 clocks per 832-clock period; 24 clocks of front porch after 640 active.
REQ-032 SHALL cover: defaults -> vsync low 3 lines, starting line 489; 28 back-porch lines; then 480 active lines.
REQ-033 SHALL cover: rgb_in=3'b111 constant -> rgb=7 for exactly 640 clocks per line on 480 lines, 0 otherwise.
REQ-034 SHALL cover: pix_en toggling every other clock -> hsync period 1664 clocks, low for 128 clocks.
REQ-035 SHALL cover: reset asserted at line 200 -> outputs at idle levels immediately; frame_cnt=0; frame_start pulse after release.
REQ-036 SHALL cover: HSYNC_POL=1, VSYNC_POL=1, run 3 frames -> sync pulses high and frame_cnt=3.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default VGA timing constants and shared types for the parallax video timing block.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 24;
  localparam int DEF_H_SYNC   = 64;
  localparam int DEF_H_BACK   = 104;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 9;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BACK   = 28;

  // Counters are 10 bits wide, so a full period may not exceed this.
  localparam int CNT_MAX = 1024;

  // Raw (undelayed, polarity-free) video control decoded from the counters.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vid_ctl_t;

  localparam int CTL_W = $bits(vid_ctl_t);

  function automatic int vga_total(input int act, input int front, input int sync, input int back);
    return act + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; clears to zero so delayed control reads as idle.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
    $error("vga_delay_line: WIDTH and DEPTH must be >= 1");
  end

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int s = 1; s < DEPTH; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/parallax_vga_timing.sv
// VGA raster timing: h/v counters, decodes, and sync/colour outputs aligned to a
// pixel source with PIPE ticks of latency.
module parallax_vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int RGB_W     = 3,
  parameter int PIPE      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      RGB_W < 1 || PIPE < 1) begin : g_bad_param
    $error("parallax_vga_timing: timing parameters, RGB_W and PIPE must be >= 1");
  end

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("parallax_vga_timing: H_TOTAL/V_TOTAL exceed the 10-bit counters");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] h, v;
  logic       h_last, v_last;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v         <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v <= v + 10'd1;
        end
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  assign x           = h;
  assign y           = v;
  assign active      = (h < H_ACT) && (v < V_ACT);
  assign line_start  = (h == '0);
  assign frame_start = (h == '0) && (v == '0);

  vid_ctl_t raw, dly;

  assign raw.hs  = (h >= HS_BEG) && (h < HS_END);
  assign raw.vs  = (v >= VS_BEG) && (v < VS_END);
  assign raw.act = active;

  vga_delay_line #(
    .WIDTH(CTL_W),
    .DEPTH(PIPE)
  ) u_dly (
    .clk  (clk),
    .rst_n(reset),
    .en   (pix_en),
    .din  (raw),
    .dout (dly)
  );

  // Final output register: rgb_in arrives here aligned with the delayed control,
  // so blanking the colour with dly.act also keeps it zero under both syncs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      rgb   <= '0;
    end else if (pix_en) begin
      hsync <= dly.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync <= dly.vs ? VSYNC_POL : ~VSYNC_POL;
      rgb   <= dly.act ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_parallax_vga_timing.sv
// Bench: default-timing instance for line-level behaviour, reduced-timing
// active-high-sync instance for frame-level behaviour; scoreboarded outputs.
module tb_parallax_vga_timing;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, pipe;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } out_t;

  localparam int BHA = 16, BHF = 2, BHS = 4, BHB = 3;
  localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;
  localparam int BPIPE = 3;

  logic       clk = 1'b0;
  logic       reset, pix_en;
  logic [2:0] rgb_a, rgb_b;
  logic [9:0] xa, ya, xb, yb;
  logic       act_a, ls_a, fs_a, hs_a, vs_a;
  logic       act_b, ls_b, fs_b, hs_b, vs_b;
  logic [7:0] fc_a, fc_b;
  logic [2:0] ro_a, ro_b;

  always #5 clk = ~clk;

  parallax_vga_timing u_a (
    .clk(clk), .reset(reset), .pix_en(pix_en), .rgb_in(rgb_a),
    .x(xa), .y(ya), .active(act_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fc_a), .hsync(hs_a), .vsync(vs_a), .rgb(ro_a)
  );

  parallax_vga_timing #(
    .H_ACTIVE(BHA), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_ACTIVE(BVA), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .RGB_W(3), .PIPE(BPIPE)
  ) u_b (
    .clk(clk), .reset(reset), .pix_en(pix_en), .rgb_in(rgb_b),
    .x(xb), .y(yb), .active(act_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fc_b), .hsync(hs_b), .vsync(vs_b), .rgb(ro_b)
  );

  cfg_t ca, cb;
  int   total = 0, bad = 0;
  int   n = 0, cyc = 0;
  bit   cmode = 1'b0;
  out_t qa[$], qb[$];
  out_t la, lb;

  // line/frame measurements
  int   a_fall, a_period, a_low, a_low_run, a_porch, a_last_rgb, a_rgb7, a_line_rgb;
  int   b_vpulse, b_vrun, b_vlen, b_rgb7, b_frame_rgb, viol;
  bit   b_vseen;
  logic pa_hs, pb_vs;

  function automatic int ht(cfg_t c); return c.ha + c.hf + c.hsw + c.hb; endfunction
  function automatic int vt(cfg_t c); return c.va + c.vf + c.vsw + c.vb; endfunction

  function automatic logic [2:0] color(int h, int v, bit cm);
    return cm ? 3'd7 : 3'((h + 2 * v + 1) % 8);
  endfunction

  function automatic logic [2:0] src(cfg_t c, int j, bit cm);
    if (j < 0) return 3'($urandom);
    return color(j % ht(c), (j / ht(c)) % vt(c), cm);
  endfunction

  function automatic out_t exp_out(cfg_t c, int j, bit cm);
    out_t o;
    int   h, v;
    o.hs  = ~c.hp;
    o.vs  = ~c.vp;
    o.rgb = '0;
    if (j >= 0) begin
      h = j % ht(c);
      v = (j / ht(c)) % vt(c);
      if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) o.hs = c.hp;
      if (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) o.vs = c.vp;
      if (h < c.ha && v < c.va) o.rgb = color(h, v, cm);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_dut(input string p, input cfg_t c, input logic [9:0] xo, input logic [9:0] yo,
                         input logic ao, input logic lo, input logic fo, input logic [7:0] fco,
                         input out_t oo, input out_t eo);
    int h, v;
    h = n % ht(c);
    v = (n / ht(c)) % vt(c);
    chk({p, ".x"}, 32'(xo), 32'(h));
    chk({p, ".y"}, 32'(yo), 32'(v));
    chk({p, ".active"}, 32'(ao), 32'(h < c.ha && v < c.va));
    chk({p, ".line_start"}, 32'(lo), 32'(h == 0));
    chk({p, ".frame_start"}, 32'(fo), 32'(h == 0 && v == 0));
    chk({p, ".frame_cnt"}, 32'(fco), 32'((n / (ht(c) * vt(c))) % 256));
    chk({p, ".hsync"}, 32'(oo.hs), 32'(eo.hs));
    chk({p, ".vsync"}, 32'(oo.vs), 32'(eo.vs));
    chk({p, ".rgb"}, 32'(oo.rgb), 32'(eo.rgb));
  endtask

  task automatic chk_idle(input string p);
    chk({p, ".A.hsync"}, 32'(hs_a), 32'(1));
    chk({p, ".A.vsync"}, 32'(vs_a), 32'(1));
    chk({p, ".A.rgb"}, 32'(ro_a), 32'(0));
    chk({p, ".A.x"}, 32'(xa), 32'(0));
    chk({p, ".A.y"}, 32'(ya), 32'(0));
    chk({p, ".A.frame_cnt"}, 32'(fc_a), 32'(0));
    chk({p, ".B.hsync"}, 32'(hs_b), 32'(0));
    chk({p, ".B.vsync"}, 32'(vs_b), 32'(0));
    chk({p, ".B.rgb"}, 32'(ro_b), 32'(0));
    chk({p, ".B.y"}, 32'(yb), 32'(0));
    chk({p, ".B.frame_cnt"}, 32'(fc_b), 32'(0));
  endtask

  task automatic meas_clear();
    a_fall = -1; a_period = -1; a_low = -1; a_low_run = 0; a_porch = -1;
    a_last_rgb = -1000; a_rgb7 = 0; a_line_rgb = -1;
    b_vpulse = 0; b_vrun = 0; b_vlen = -1; b_rgb7 = 0; b_frame_rgb = -1; b_vseen = 1'b0;
    viol = 0;
    pa_hs = hs_a; pb_vs = vs_b;
  endtask

  task automatic measure();
    if (hs_a === 1'b0 && pa_hs === 1'b1) begin
      if (a_fall >= 0) begin
        a_period   = cyc - a_fall;
        a_line_rgb = a_rgb7;
      end
      a_fall  = cyc;
      a_porch = cyc - a_last_rgb - 1;
      a_rgb7  = 0;
    end
    if (hs_a === 1'b0) a_low_run++;
    else if (pa_hs === 1'b0) begin a_low = a_low_run; a_low_run = 0; end
    if (ro_a != 3'd0) a_last_rgb = cyc;
    if (ro_a == 3'd7) a_rgb7++;

    if (vs_b === 1'b1 && pb_vs === 1'b0) begin
      b_vpulse++;
      if (b_vseen) b_frame_rgb = b_rgb7;
      b_vseen = 1'b1;
      b_rgb7  = 0;
    end
    if (vs_b === 1'b1) b_vrun++;
    else if (pb_vs === 1'b1) begin b_vlen = b_vrun; b_vrun = 0; end
    if (ro_b == 3'd7) b_rgb7++;

    if ((hs_a === 1'b0 || vs_a === 1'b0) && ro_a != 3'd0) viol++;
    if ((hs_b === 1'b1 || vs_b === 1'b1) && ro_b != 3'd0) viol++;
    pa_hs = hs_a;
    pb_vs = vs_b;
  endtask

  // One clock; expected outputs are queued as the matching colour is driven.
  task automatic step(input bit en);
    pix_en = en;
    if (en) begin
      rgb_a = src(ca, n - ca.pipe, cmode);
      rgb_b = src(cb, n - cb.pipe, cmode);
      qa.push_back(exp_out(ca, n - ca.pipe, cmode));
      qb.push_back(exp_out(cb, n - cb.pipe, cmode));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (en) begin
      n++;
      la = qa.pop_front();
      lb = qb.pop_front();
    end
    chk_dut("A", ca, xa, ya, act_a, ls_a, fs_a, fc_a, {hs_a, vs_a, ro_a}, la);
    chk_dut("B", cb, xb, yb, act_b, ls_b, fs_b, fc_b, {hs_b, vs_b, ro_b}, lb);
    measure();
  endtask

  task automatic release_reset();
    reset = 1'b1;
    n = 0;
    qa.delete();
    qb.delete();
    la = exp_out(ca, -1, 1'b0);
    lb = exp_out(cb, -1, 1'b0);
    #1;
    chk("rel.A.frame_start", 32'(fs_a), 32'(1));
    chk("rel.B.frame_start", 32'(fs_b), 32'(1));
    meas_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ca = '{640, 24, 64, 104, 480, 9, 3, 28, 2, 1'b0, 1'b0};
    cb = '{BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, BPIPE, 1'b1, 1'b1};
    reset = 1'b0; pix_en = 1'b0; rgb_a = '0; rgb_b = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    release_reset();

    // random colours, pix_en=1: line geometry of the default timing
    repeat (3 * 832) step(1'b1);
    chk("A.hs_period", 32'(a_period), 32'(832));
    chk("A.hs_low", 32'(a_low), 32'(64));
    chk("B.vs_len", 32'(b_vlen), 32'(BVS * (BHA + BHF + BHS + BHB)));

    // constant white source: active extent and front porch
    cmode = 1'b1;
    meas_clear();
    repeat (2000) step(1'b1);
    chk("A.line_rgb7", 32'(a_line_rgb), 32'(640));
    chk("A.front_porch", 32'(a_porch), 32'(24));
    chk("B.frame_rgb7", 32'(b_frame_rgb), 32'(BHA * BVA));
    chk("sync_rgb_overlap", 32'(viol), 32'(0));

    // pix_en every other clock
    cmode = 1'b0;
    meas_clear();
    for (int i = 0; i < 2 * 1664 + 300; i++) step(i % 2 == 0);
    chk("A.hs_period_half", 32'(a_period), 32'(1664));
    chk("A.hs_low_half", 32'(a_low), 32'(128));

    // reset in the middle of a frame
    for (int i = 0; i < 1000 && ((n / ht(cb)) % vt(cb)) != 7; i++) step(1'b1);
    chk("B.mid_line", 32'(yb), 32'(7));
    reset = 1'b0;
    #1;
    chk_idle("async");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_idle("hold");
    end
    release_reset();

    // three frames on the active-high instance
    repeat (3 * 475) step(1'b1);
    chk("B.frame_cnt3", 32'(fc_b), 32'(3));
    chk("B.vs_pulses", 32'(b_vpulse), 32'(3));
    chk("sync_rgb_overlap2", 32'(viol), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
